// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter; ARB_PACKET_LOCK_EN pins grants to a packet
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 8,
  localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_valid,
  output logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_ready,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic                          busy
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t              state;
  logic [ID_WIDTH-1:0] last_ptr;
  logic [ID_WIDTH-1:0] winner;
  logic                found;

`ifdef ARB_PACKET_LOCK_EN
  logic lock;
`else
  logic unused_last;
  assign unused_last = ^req_last;
`endif

  // Scan downwards so the requester closest after last_ptr is written last and wins.
  always_comb begin
    int idx;
    idx    = 0;
    winner = last_ptr;
    found  = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = int'(last_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid[ID_WIDTH'(idx)]) begin
        winner = ID_WIDTH'(idx);
        found  = 1'b1;
      end
    end
`ifdef ARB_PACKET_LOCK_EN
    if (lock) begin
      winner = last_ptr;
      found  = req_valid[last_ptr];
    end
`endif
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && state == IDLE && found) req_ready[winner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      last_ptr <= ID_WIDTH'(NUM_REQ - 1);
`ifdef ARB_PACKET_LOCK_EN
      lock     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            tx_data  <= req_data[int'(winner) * DATA_WIDTH +: DATA_WIDTH];
            tx_valid <= 1'b1;
            last_ptr <= winner;
            grant_id <= winner;
            busy     <= 1'b1;
            state    <= SEND;
`ifdef ARB_PACKET_LOCK_EN
            lock     <= ~req_last[winner];
`endif
          end
        end
        SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
